// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared constants and types for the VGA pixel source.
//   - Default 640x480@60 raster timing and the derived line/frame totals
//   - Default stored-image size, frame-buffer read latency and address width
//   - rgb888_t: one frame-buffer word, {R,G,B}
//   - pix_tag_t: per-pixel side information carried alongside the BRAM read
// ---------------------------------------------------------------------------
package vga_pkg;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;

  localparam int unsigned VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int unsigned VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam int unsigned VGA_IMG_W  = 320;
  localparam int unsigned VGA_IMG_H  = 240;
  localparam int unsigned VGA_RD_LAT = 2;
  localparam int unsigned VGA_ADDR_W = 17;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  // valid=0 marks a stage that holds no real pixel (after reset); such a
  // stage must produce black, de=0 and inactive syncs at the output.
  typedef struct packed {
    logic       valid;
    logic       active;
    logic       in_img;
    logic       hs_n;
    logic       vs_n;
    logic [1:0] x_lsb;
    logic [1:0] y_lsb;
    logic       first;
  } pix_tag_t;

  function automatic rgb888_t rgb_or_black(input logic keep, input rgb888_t px);
    return keep ? px : '0;
  endfunction

endpackage

// File: rtl/vga_pixel_source_if.sv
// ---------------------------------------------------------------------------
// vga_pixel_source_if
// Frame-buffer read port between the pixel source and its BRAM.
//   rd_en   : read strobe (source -> memory)
//   rd_addr : word address (source -> memory)
//   rd_data : {R,G,B} word, valid a fixed number of pixel steps after rd_en
//             and held until the next read (memory -> source)
// Modports: master = pixel source, slave = memory.
// ---------------------------------------------------------------------------
interface vga_pixel_source_if #(
  parameter int unsigned ADDR_W = vga_pkg::VGA_ADDR_W
) ();
  import vga_pkg::*;

  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  rgb888_t           rd_data;

  modport master (output rd_en, output rd_addr, input  rd_data);
  modport slave  (input  rd_en, input  rd_addr, output rd_data);

endinterface

// File: rtl/vga_timing_counter.sv
// ---------------------------------------------------------------------------
// vga_timing_counter
// Horizontal/vertical raster counters and the combinational region flags
// derived from them. Counters advance only on pixel-clock-enable steps.
//   clk, rst_n     : clock, synchronous active-low reset
//   i_pix_ce       : pixel clock enable
//   o_active       : inside the visible area
//   o_in_img       : inside the stored image (top-left of the raster)
//   o_hs_n/o_vs_n  : raw active-low sync levels for the current position
//   o_first        : current position is pixel (0,0)
//   o_frame_wrap   : current position is the last of the frame
//   o_x_lsb/o_y_lsb: low two bits of the current position
// ---------------------------------------------------------------------------
module vga_timing_counter
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP,
  parameter int unsigned IMG_W    = VGA_IMG_W,
  parameter int unsigned IMG_H    = VGA_IMG_H
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_pix_ce,
  output logic       o_active,
  output logic       o_in_img,
  output logic       o_hs_n,
  output logic       o_vs_n,
  output logic       o_first,
  output logic       o_frame_wrap,
  output logic [1:0] o_x_lsb,
  output logic [1:0] o_y_lsb
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HCW     = $clog2(H_TOTAL);
  localparam int unsigned VCW     = $clog2(V_TOTAL);

  logic [HCW-1:0] r_hcnt;
  logic [VCW-1:0] r_vcnt;
  logic           w_h_last;
  logic           w_v_last;
  logic [31:0]    w_h;
  logic [31:0]    w_v;

  always_comb begin
    w_h      = 32'(r_hcnt);
    w_v      = 32'(r_vcnt);
    w_h_last = (w_h == H_TOTAL - 1);
    w_v_last = (w_v == V_TOTAL - 1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (i_pix_ce) begin
      if (w_h_last) begin
        r_hcnt <= '0;
        r_vcnt <= w_v_last ? '0 : r_vcnt + 1'b1;
      end else begin
        r_hcnt <= r_hcnt + 1'b1;
      end
    end
  end

  // Compares are done at 32 bits so the sync-end bound may equal the total
  // even when the total is a power of two.
  always_comb begin
    o_active     = (w_h < H_ACTIVE) && (w_v < V_ACTIVE);
    o_in_img     = (w_h < IMG_W) && (w_v < IMG_H);
    o_hs_n       = !((w_h >= H_ACTIVE + H_FP) && (w_h < H_ACTIVE + H_FP + H_SYNC));
    o_vs_n       = !((w_v >= V_ACTIVE + V_FP) && (w_v < V_ACTIVE + V_FP + V_SYNC));
    o_first      = (r_hcnt == '0) && (r_vcnt == '0);
    o_frame_wrap = w_h_last && w_v_last;
    o_x_lsb      = r_hcnt[1:0];
    o_y_lsb      = r_vcnt[1:0];
  end

endmodule

// File: rtl/vga_pixel_source.sv
// ---------------------------------------------------------------------------
// vga_pixel_source
// Generates raster timing, reads RGB888 pixels from a frame-buffer BRAM and
// presents per-channel bytes with syncs/de/coordinate LSBs aligned to them.
//   clk, rst_n   : clock, synchronous active-low reset
//   pix_ce       : pixel clock enable; all state advances only when 1
//   fb (master)  : frame-buffer read port (rd_en, rd_addr, rd_data)
//   red/green/blue: channel bytes, black outside the stored image
//   x_lsb/y_lsb  : low bits of the displayed pixel's coordinates
//   hsync/vsync  : active-low syncs; de: display enable
//   frame_start  : one-clk pulse with the first output of pixel (0,0)
// Counter-to-output latency is RD_LAT+1 pix_ce steps for data and sync.
// ---------------------------------------------------------------------------
module vga_pixel_source
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP,
  parameter int unsigned IMG_W    = VGA_IMG_W,
  parameter int unsigned IMG_H    = VGA_IMG_H,
  parameter int unsigned RD_LAT   = VGA_RD_LAT,
  parameter int unsigned ADDR_W   = VGA_ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pix_ce,
  vga_pixel_source_if.master   fb,
  output logic [7:0]           red,
  output logic [7:0]           green,
  output logic [7:0]           blue,
  output logic [1:0]           x_lsb,
  output logic [1:0]           y_lsb,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 de,
  output logic                 frame_start
);

  logic       w_active;
  logic       w_in_img;
  logic       w_hs_n;
  logic       w_vs_n;
  logic       w_first;
  logic       w_frame_wrap;
  logic [1:0] w_x_lsb;
  logic [1:0] w_y_lsb;

  vga_timing_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .IMG_W    (IMG_W),
    .IMG_H    (IMG_H)
  ) u_timing (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_pix_ce     (pix_ce),
    .o_active     (w_active),
    .o_in_img     (w_in_img),
    .o_hs_n       (w_hs_n),
    .o_vs_n       (w_vs_n),
    .o_first      (w_first),
    .o_frame_wrap (w_frame_wrap),
    .o_x_lsb      (w_x_lsb),
    .o_y_lsb      (w_y_lsb)
  );

  logic [ADDR_W-1:0] r_rd_addr;
  pix_tag_t          r_pipe [RD_LAT];
  pix_tag_t          w_tag;
  pix_tag_t          w_tail;
  rgb888_t           r_rgb;
  logic [1:0]        r_x_lsb;
  logic [1:0]        r_y_lsb;
  logic              r_hsync;
  logic              r_vsync;
  logic              r_de;
  logic              r_frame_start;

  // rd_addr always holds the word address of the current raster position;
  // the strobe is taken on the same pix_ce edge that advances the counters,
  // so the BRAM registers this address together with the pipeline tag.
  assign fb.rd_en   = rst_n & pix_ce & w_in_img;
  assign fb.rd_addr = r_rd_addr;

  always_comb begin
    w_tag = '{valid: 1'b1, active: w_active, in_img: w_in_img,
              hs_n: w_hs_n, vs_n: w_vs_n, x_lsb: w_x_lsb,
              y_lsb: w_y_lsb, first: w_first};
    w_tail = r_pipe[RD_LAT-1];
  end

  // Row-major address without a multiplier: pixels outside the image do not
  // consume addresses, and the count restarts on the last step of the frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_addr <= '0;
    end else if (pix_ce) begin
      if (w_frame_wrap) begin
        r_rd_addr <= '0;
      end else if (w_in_img) begin
        r_rd_addr <= r_rd_addr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        r_pipe[i] <= '0;
      end
    end else if (pix_ce) begin
      r_pipe[0] <= w_tag;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rgb   <= '0;
      r_x_lsb <= '0;
      r_y_lsb <= '0;
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
      r_de    <= 1'b0;
    end else if (pix_ce) begin
      r_rgb   <= rgb_or_black(w_tail.valid & w_tail.in_img, fb.rd_data);
      r_x_lsb <= w_tail.x_lsb;
      r_y_lsb <= w_tail.y_lsb;
      r_hsync <= ~w_tail.valid | w_tail.hs_n;
      r_vsync <= ~w_tail.valid | w_tail.vs_n;
      r_de    <= w_tail.valid & w_tail.active;
    end
  end

  // Loaded every clk (not only on pix_ce) so the pulse drops after one clk
  // even when the following pix_ce steps are stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= pix_ce & w_tail.valid & w_tail.first;
    end
  end

  assign red         = r_rgb.r;
  assign green       = r_rgb.g;
  assign blue        = r_rgb.b;
  assign x_lsb       = r_x_lsb;
  assign y_lsb       = r_y_lsb;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign de          = r_de;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_pixel_source.sv
// ---------------------------------------------------------------------------
// tb_vga_pixel_source
// Two instances share clk/rst_n/pix_ce: one with the full 640x480 raster,
// one with a small raster so several whole frames fit in a short run.
// Each has a behavioural BRAM (delay line) returning a scrambled function
// of the address. Expected outputs come from the pixel index: the n-th
// pix_ce step after reset is raster position n, and the outputs after n
// steps show position n-1-RD_LAT.
// ---------------------------------------------------------------------------
module tb_vga_pixel_source;
  import vga_pkg::*;

  localparam int unsigned RD_LAT = 2;
  localparam int unsigned ADDR_W = 17;

  typedef struct packed {
    int unsigned ha, hf, hs, hb, va, vf, vs, vb, iw, ih;
  } geom_t;

  localparam geom_t G_FULL  = '{ha: 640, hf: 16, hs: 96, hb: 48,
                                va: 480, vf: 10, vs: 2,  vb: 33,
                                iw: 320, ih: 240};
  localparam geom_t G_SMALL = '{ha: 40, hf: 4, hs: 6, hb: 6,
                                va: 30, vf: 2, vs: 2, vb: 3,
                                iw: 20, ih: 15};

  typedef struct packed {
    logic [23:0] rgb;
    logic [1:0]  x;
    logic [1:0]  y;
    logic        hs;
    logic        vs;
    logic        de;
    logic        fs;
  } vout_t;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic pix_ce = 1'b0;
  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  int unsigned n        = 0;
  bit          last_ce  = 1'b0;
  bit          chk_en   = 1'b0;

  vga_pixel_source_if #(.ADDR_W(ADDR_W)) f_if ();
  vga_pixel_source_if #(.ADDR_W(ADDR_W)) s_if ();

  logic [7:0] f_red, f_green, f_blue, s_red, s_green, s_blue;
  logic [1:0] f_x_lsb, f_y_lsb, s_x_lsb, s_y_lsb;
  logic       f_hsync, f_vsync, f_de, f_frame_start;
  logic       s_hsync, s_vsync, s_de, s_frame_start;

  vga_pixel_source #(
    .H_ACTIVE (G_FULL.ha), .H_FP (G_FULL.hf), .H_SYNC (G_FULL.hs), .H_BP (G_FULL.hb),
    .V_ACTIVE (G_FULL.va), .V_FP (G_FULL.vf), .V_SYNC (G_FULL.vs), .V_BP (G_FULL.vb),
    .IMG_W (G_FULL.iw), .IMG_H (G_FULL.ih), .RD_LAT (RD_LAT), .ADDR_W (ADDR_W)
  ) u_full (
    .clk (clk), .rst_n (rst_n), .pix_ce (pix_ce), .fb (f_if),
    .red (f_red), .green (f_green), .blue (f_blue),
    .x_lsb (f_x_lsb), .y_lsb (f_y_lsb),
    .hsync (f_hsync), .vsync (f_vsync), .de (f_de), .frame_start (f_frame_start)
  );

  vga_pixel_source #(
    .H_ACTIVE (G_SMALL.ha), .H_FP (G_SMALL.hf), .H_SYNC (G_SMALL.hs), .H_BP (G_SMALL.hb),
    .V_ACTIVE (G_SMALL.va), .V_FP (G_SMALL.vf), .V_SYNC (G_SMALL.vs), .V_BP (G_SMALL.vb),
    .IMG_W (G_SMALL.iw), .IMG_H (G_SMALL.ih), .RD_LAT (RD_LAT), .ADDR_W (ADDR_W)
  ) u_small (
    .clk (clk), .rst_n (rst_n), .pix_ce (pix_ce), .fb (s_if),
    .red (s_red), .green (s_green), .blue (s_blue),
    .x_lsb (s_x_lsb), .y_lsb (s_y_lsb),
    .hsync (s_hsync), .vsync (s_vsync), .de (s_de), .frame_start (s_frame_start)
  );

  function automatic logic [23:0] fb_word(input int unsigned a);
    return 24'(a * 32'd40503 + 32'd13);
  endfunction

  // Behavioural BRAMs: a read taken on a pix_ce edge appears on rd_data
  // RD_LAT-1 further pix_ce edges later and is held until replaced.
  logic              fm_v [RD_LAT];
  logic [ADDR_W-1:0] fm_a [RD_LAT];
  logic              sm_v [RD_LAT];
  logic [ADDR_W-1:0] sm_a [RD_LAT];

  initial begin
    for (int i = 0; i < int'(RD_LAT); i++) begin
      fm_v[i] = 1'b0; fm_a[i] = '0; sm_v[i] = 1'b0; sm_a[i] = '0;
    end
    f_if.rd_data = '0;
    s_if.rd_data = '0;
  end

  always @(posedge clk) begin
    if (pix_ce) begin
      for (int i = int'(RD_LAT) - 1; i > 0; i--) begin
        fm_v[i] = fm_v[i-1]; fm_a[i] = fm_a[i-1];
        sm_v[i] = sm_v[i-1]; sm_a[i] = sm_a[i-1];
      end
      fm_v[0] = f_if.rd_en; fm_a[0] = f_if.rd_addr;
      sm_v[0] = s_if.rd_en; sm_a[0] = s_if.rd_addr;
      if (fm_v[RD_LAT-1]) f_if.rd_data <= fb_word(32'(fm_a[RD_LAT-1]));
      if (sm_v[RD_LAT-1]) s_if.rd_data <= fb_word(32'(sm_a[RD_LAT-1]));
    end
  end

  function automatic vout_t model_out(input geom_t g, input int unsigned steps, input bit ce_edge);
    vout_t       o;
    int unsigned ht, vt, idx, x, y;
    o    = '0;
    o.hs = 1'b1;
    o.vs = 1'b1;
    if (steps < RD_LAT + 1) return o;
    ht  = g.ha + g.hf + g.hs + g.hb;
    vt  = g.va + g.vf + g.vs + g.vb;
    idx = (steps - RD_LAT - 1) % (ht * vt);
    x   = idx % ht;
    y   = idx / ht;
    o.de = (x < g.ha) && (y < g.va);
    o.hs = !((x >= g.ha + g.hf) && (x < g.ha + g.hf + g.hs));
    o.vs = !((y >= g.va + g.vf) && (y < g.va + g.vf + g.vs));
    o.x  = 2'(x);
    o.y  = 2'(y);
    if ((x < g.iw) && (y < g.ih)) o.rgb = fb_word(y * g.iw + x);
    o.fs = ce_edge && (x == 0) && (y == 0);
    return o;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%h expected=%h", tag, n, got, exp);
    end
  endtask

  task automatic check_dut(input string name, input geom_t g, input vout_t got,
                           input logic ren, input logic [ADDR_W-1:0] raddr);
    int unsigned ht, vt, idx, x, y;
    bit          in_img;
    ht     = g.ha + g.hf + g.hs + g.hb;
    vt     = g.va + g.vf + g.vs + g.vb;
    idx    = n % (ht * vt);
    x      = idx % ht;
    y      = idx / ht;
    in_img = (x < g.iw) && (y < g.ih);
    check_eq({name, ".out"}, 64'(got), 64'(model_out(g, n, last_ce)));
    check_eq({name, ".rd_en"}, 64'(ren), 64'(rst_n && pix_ce && in_img));
    if (in_img) check_eq({name, ".rd_addr"}, 64'(raddr), 64'(y * g.iw + x));
  endtask

  // Inputs change 1 time unit after posedge; outputs are checked at negedge.
  task automatic cycle(input logic rst, input logic ce);
    rst_n  = rst;
    pix_ce = ce;
    @(negedge clk);
    if (chk_en) begin
      check_dut("full", G_FULL,
                {f_red, f_green, f_blue, f_x_lsb, f_y_lsb, f_hsync, f_vsync, f_de, f_frame_start},
                f_if.rd_en, f_if.rd_addr);
      check_dut("small", G_SMALL,
                {s_red, s_green, s_blue, s_x_lsb, s_y_lsb, s_hsync, s_vsync, s_de, s_frame_start},
                s_if.rd_en, s_if.rd_addr);
    end
    @(posedge clk);
    chk_en = 1'b1;
    if (!rst) begin
      n       = 0;
      last_ce = 1'b0;
    end else if (ce) begin
      n++;
      last_ce = 1'b1;
    end else begin
      last_ce = 1'b0;
    end
    #1;
  endtask

  initial begin
    #1;
    repeat (5) cycle(1'b0, 1'b1);
    // Continuous pixel clock up to full-raster position (200,50); the small
    // raster wraps many frames meanwhile.
    while (n < 800 * 50 + 200) cycle(1'b1, 1'b1);
    cycle(1'b0, 1'b1);
    for (int i = 0; i < 12000; i++) cycle(1'b1, (i % 4) == 0);
    for (int i = 0; i < 8000; i++) cycle(1'b1, $urandom_range(0, 2) != 0);
    cycle(1'b0, 1'b0);
    for (int i = 0; i < 3000; i++) cycle(1'b1, $urandom_range(0, 1) != 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
